wb_cmd_master: RTL and testbench

//  Wishbone B4 classic single-transfer bus initiator. Turns one command (valid/ready) into one
//  WB read or write cycle, then returns one response (valid/ready) with read data and error.

---
 rtl/wb_cmd_master.sv | 164 ++++++++++++++++
 tb/tb_wb_cmd_master.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// Wishbone B4 classic single-transfer initiator.
// Turns one valid/ready command into one WB read or write cycle and returns
// one valid/ready response carrying read data, an error flag and a timeout
// flag. A bus timeout keeps a missing slave from hanging the host.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a command; cmd_ready_o is high
// BUS   | cyc/stb asserted, waiting for ack, err or timeout
// RESP  | response presented, waiting for rsp_ready_i
module wb_cmd_master #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_WD   = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [AW-1:0]     cmd_adr_i,
    input  logic [DW-1:0]     cmd_dat_i,
    input  logic [DW/8-1:0]   cmd_sel_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DW-1:0]     rsp_dat_o,
    output logic              rsp_err_o,
    output logic              rsp_to_o,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [AW-1:0]     wbm_adr_o,
    output logic [DW-1:0]     wbm_dat_o,
    output logic [DW/8-1:0]   wbm_sel_o,
    input  logic [DW-1:0]     wbm_dat_i,
    input  logic              wbm_ack_i,
    input  logic              wbm_err_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Count value on the last stb cycle; only meaningful when TIMEOUT != 0.
    localparam logic [TO_WD-1:0] CNT_LAST = TO_WD'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [TO_WD-1:0] CNT_MAX  = '1;
    localparam bit               TO_EN    = (TIMEOUT != 0);

    state_t              state_q;
    logic [TO_WD-1:0]    cnt_q;
    logic [TO_WD-1:0]    cnt_d;
    logic                timeout_hit;
    logic                bus_done;

    logic                wbm_cyc_q;
    logic                wbm_stb_q;
    logic                wbm_we_q;
    logic [AW-1:0]       wbm_adr_q;
    logic [DW-1:0]       wbm_dat_q;
    logic [DW/8-1:0]     wbm_sel_q;

    logic                rsp_valid_q;
    logic [DW-1:0]       rsp_dat_q;
    logic                rsp_err_q;
    logic                rsp_to_q;
    logic                busy_q;

    logic [DW-1:0]       rsp_dat_d;
    logic                rsp_err_d;
    logic                rsp_to_d;

    // Termination decode for the BUS state; err outranks ack, both outrank timeout.
    always_comb begin
        cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + TO_WD'(1);
        timeout_hit = TO_EN && (cnt_q == CNT_LAST);
        bus_done    = wbm_err_i || wbm_ack_i || timeout_hit;
        rsp_err_d   = wbm_err_i || (!wbm_ack_i && timeout_hit);
        rsp_to_d    = !wbm_err_i && !wbm_ack_i && timeout_hit;
        rsp_dat_d   = (!wbm_err_i && wbm_ack_i && !wbm_we_q) ? wbm_dat_i : '0;
    end

    // Command FSM with registered bus and response outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wbm_cyc_q   <= 1'b0;
            wbm_stb_q   <= 1'b0;
            wbm_we_q    <= 1'b0;
            wbm_adr_q   <= '0;
            wbm_dat_q   <= '0;
            wbm_sel_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        wbm_we_q  <= cmd_we_i;
                        wbm_adr_q <= cmd_adr_i;
                        wbm_dat_q <= cmd_dat_i;
                        wbm_sel_q <= cmd_sel_i;
                        wbm_cyc_q <= 1'b1;
                        wbm_stb_q <= 1'b1;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (bus_done) begin
                        wbm_cyc_q   <= 1'b0;
                        wbm_stb_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_dat_q   <= rsp_dat_d;
                        rsp_err_q   <= rsp_err_d;
                        rsp_to_q    <= rsp_to_d;
                        state_q     <= ST_RESP;
                    end else begin
                        // Saturates when the timeout is disabled, so it never wraps.
                        cnt_q <= cnt_d;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    wbm_cyc_q   <= 1'b0;
                    wbm_stb_q   <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    // Only cmd_ready_o is combinational so a command can be taken in the IDLE cycle itself.
    assign cmd_ready_o = (state_q == ST_IDLE);

    assign wbm_cyc_o   = wbm_cyc_q;
    assign wbm_stb_o   = wbm_stb_q;
    assign wbm_we_o    = wbm_we_q;
    assign wbm_adr_o   = wbm_adr_q;
    assign wbm_dat_o   = wbm_dat_q;
    assign wbm_sel_o   = wbm_sel_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_to_o    = rsp_to_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Testbench for wb_cmd_master: directed scenarios plus randomized
// transactions checked against an outcome model of the bus transfer.
module tb_wb_cmd_master;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TOUT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        rsp_to;
    logic        wbm_cyc;
    logic        wbm_stb;
    logic        wbm_we;
    logic [31:0] wbm_adr;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel;
    logic [31:0] wdat_i = '0;
    logic        ack = 1'b0;
    logic        err = 1'b0;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    wb_cmd_master #(.AW(AW), .DW(DW), .TIMEOUT(TOUT), .TO_WD(8)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .cmd_sel_i   (cmd_sel),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err),
        .rsp_to_o    (rsp_to),
        .wbm_cyc_o   (wbm_cyc),
        .wbm_stb_o   (wbm_stb),
        .wbm_we_o    (wbm_we),
        .wbm_adr_o   (wbm_adr),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_sel_o   (wbm_sel),
        .wbm_dat_i   (wdat_i),
        .wbm_ack_i   (ack),
        .wbm_err_i   (err),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    // Outcome of one transfer from the slave behaviour alone.
    // ack_at: stb cycle (1-based) in which the slave answers, 0 = never.
    // err_mode: 0 ack only, 1 err only, 2 err and ack together.
    function automatic void ref_rsp(input logic we, input int ack_at, input int err_mode,
                                    input logic [31:0] rdata, output int stb_cycles,
                                    output logic e, output logic t, output logic [31:0] d);
        if (ack_at < 1 || ack_at > TOUT) begin
            stb_cycles = TOUT; e = 1'b1; t = 1'b1; d = 32'h0;
        end else begin
            stb_cycles = ack_at; t = 1'b0;
            if (err_mode != 0) begin
                e = 1'b1; d = 32'h0;
            end else begin
                e = 1'b0; d = we ? 32'h0 : rdata;
            end
        end
    endfunction

    task automatic run_txn(input string tag, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel, input int ack_at,
                           input int err_mode, input logic [31:0] rdata, input int bp);
        int          exp_stb;
        logic        exp_err, exp_to;
        logic [31:0] exp_dat;
        int          stb_cnt;
        int          waited;
        logic [70:0] obs, expv;
        ref_rsp(we, ack_at, err_mode, rdata, exp_stb, exp_err, exp_to, exp_dat);

        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL %s idle_ready: got %b want 1", tag, cmd_ready);
        else n_pass++;

        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_we  = 1'($urandom_range(0, 1));
        cmd_adr = $urandom;
        cmd_dat = $urandom;
        cmd_sel = 4'($urandom);

        stb_cnt = 0;
        waited  = 0;
        while (wbm_stb === 1'b1 && waited < 300) begin
            stb_cnt++;
            obs  = {wbm_cyc, wbm_we, wbm_adr, wbm_dat_o, wbm_sel, cmd_ready};
            expv = {1'b1, we, adr, dat, sel, 1'b0};
            n_checks++;
            if (obs !== expv) $display("FAIL %s bus_hold: got %h want %h", tag, obs, expv);
            else n_pass++;
            if (stb_cnt == ack_at) begin
                err = (err_mode != 0); ack = (err_mode != 1); wdat_i = rdata;
            end else begin
                err = 1'b0; ack = 1'b0; wdat_i = $urandom;
            end
            @(negedge clk);
            waited++;
        end
        ack = 1'b0; err = 1'b0;

        n_checks++;
        if (stb_cnt != exp_stb) $display("FAIL %s stb_cycles: got %0d want %0d", tag, stb_cnt, exp_stb);
        else n_pass++;
        n_checks++;
        if ({wbm_cyc, rsp_valid, rsp_err, rsp_to, busy, cmd_ready} !== {1'b0, 1'b1, exp_err, exp_to, 1'b1, 1'b0})
            $display("FAIL %s rsp_flags: got cyc=%b v=%b e=%b t=%b busy=%b rdy=%b want cyc=0 v=1 e=%b t=%b busy=1 rdy=0",
                     tag, wbm_cyc, rsp_valid, rsp_err, rsp_to, busy, cmd_ready, exp_err, exp_to);
        else n_pass++;
        n_checks++;
        if (rsp_dat !== exp_dat) $display("FAIL %s rsp_dat: got %h want %h", tag, rsp_dat, exp_dat);
        else n_pass++;

        // Backpressure with late/spurious ack, err and ignored commands.
        for (int i = 0; i < bp; i++) begin
            ack = (i == 0 && ack_at > TOUT) ? 1'b1 : 1'($urandom_range(0, 1));
            err = ($urandom_range(0, 3) == 0);
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_adr = $urandom;
            @(negedge clk);
            n_checks++;
            if ({rsp_valid, rsp_err, rsp_to, rsp_dat, wbm_stb, wbm_cyc, cmd_ready} !==
                {1'b1, exp_err, exp_to, exp_dat, 1'b0, 1'b0, 1'b0})
                $display("FAIL %s rsp_hold: got v=%b e=%b t=%b d=%h stb=%b rdy=%b", tag,
                         rsp_valid, rsp_err, rsp_to, rsp_dat, wbm_stb, cmd_ready);
            else n_pass++;
        end
        ack = 1'b0; err = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_checks++;
        if ({rsp_valid, cmd_ready, busy, wbm_stb} !== 4'b0100)
            $display("FAIL %s handshake: got v=%b rdy=%b busy=%b stb=%b want 0 1 0 0", tag,
                     rsp_valid, cmd_ready, busy, wbm_stb);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({cmd_ready, rsp_valid, rsp_err, rsp_to, wbm_cyc, wbm_stb, wbm_we, busy} !== 8'b1000_0000)
            $display("FAIL reset_flags: got %b want 10000000",
                     {cmd_ready, rsp_valid, rsp_err, rsp_to, wbm_cyc, wbm_stb, wbm_we, busy});
        else n_pass++;
        n_checks++;
        if ({rsp_dat, wbm_adr, wbm_dat_o, wbm_sel} !== 100'h0)
            $display("FAIL reset_data: got %h want 0", {rsp_dat, wbm_adr, wbm_dat_o, wbm_sel});
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({cmd_ready, busy, wbm_stb} !== 3'b100)
            $display("FAIL reset_release: got %b want 100", {cmd_ready, busy, wbm_stb});
        else n_pass++;
    endtask

    task automatic test_read();
        run_txn("read", 1'b0, 32'h3000_0010, 32'h0, 4'hF, 3, 0, 32'hA5A5_1234, 0);
    endtask

    task automatic test_write();
        run_txn("write", 1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'h3, 1, 0, 32'h7777_8888, 0);
    endtask

    task automatic test_error();
        run_txn("error", 1'b0, 32'h3000_0008, 32'h0, 4'hF, 2, 2, 32'h1111_2222, 1);
        run_txn("error_only", 1'b1, 32'h3000_000C, 32'h55AA_55AA, 4'hC, 1, 1, 32'h3333_4444, 0);
    endtask

    task automatic test_timeout();
        run_txn("timeout", 1'b0, 32'h3000_0100, 32'h0, 4'hF, 9, 0, 32'hCAFE_F00D, 2);
        run_txn("timeout_never", 1'b1, 32'h3000_0104, 32'h0BAD_CAFE, 4'h1, 0, 0, 32'h0, 0);
        run_txn("ack_last_cycle", 1'b0, 32'h3000_0108, 32'h0, 4'hF, 8, 0, 32'h0123_4567, 0);
    endtask

    task automatic test_backpressure();
        run_txn("backpressure", 1'b0, 32'h3000_0200, 32'h0, 4'hF, 2, 0, 32'h89AB_CDEF, 5);
    endtask

    task automatic test_back_to_back();
        logic [31:0] adrs[4];
        int          rsp_at[$];
        int          accepted = 0;
        int          got = 0;
        logic [31:0] exp_d;
        for (int i = 0; i < 4; i++) adrs[i] = $urandom;
        rsp_ready = 1'b1;
        cmd_we = 1'b0; cmd_sel = 4'hF; cmd_dat = 32'h0; cmd_adr = adrs[0]; cmd_valid = 1'b1;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            ack = 1'b0;
            if (wbm_stb === 1'b1 && accepted < 4) begin
                n_checks++;
                if (wbm_adr !== adrs[accepted])
                    $display("FAIL b2b_adr: got %h want %h", wbm_adr, adrs[accepted]);
                else n_pass++;
                ack = 1'b1;
                wdat_i = adrs[accepted] ^ 32'h5A5A_0F0F;
                accepted++;
                if (accepted < 4) cmd_adr = adrs[accepted];
                else cmd_valid = 1'b0;
            end
            if (rsp_valid === 1'b1) begin
                exp_d = adrs[got] ^ 32'h5A5A_0F0F;
                n_checks++;
                if ({rsp_err, rsp_dat} !== {1'b0, exp_d})
                    $display("FAIL b2b_rsp: got e=%b d=%h want e=0 d=%h", rsp_err, rsp_dat, exp_d);
                else n_pass++;
                rsp_at.push_back(c);
                got++;
            end
        end
        ack = 1'b0; cmd_valid = 1'b0;
        n_checks++;
        if (got != 4) $display("FAIL b2b_count: got %0d want 4", got);
        else n_pass++;
        if (got == 4) begin
            n_checks++;
            if (rsp_at[0] != 1) $display("FAIL b2b_first_latency: got %0d want 1", rsp_at[0]);
            else n_pass++;
            for (int i = 1; i < 4; i++) begin
                n_checks++;
                if (rsp_at[i] - rsp_at[i-1] != 3)
                    $display("FAIL b2b_interval: got %0d want 3", rsp_at[i] - rsp_at[i-1]);
                else n_pass++;
            end
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        n_checks++;
        if ({cmd_ready, busy, rsp_valid} !== 3'b100)
            $display("FAIL b2b_idle: got %b want 100", {cmd_ready, busy, rsp_valid});
        else n_pass++;
    endtask

    task automatic test_spurious_ack();
        for (int i = 0; i < 3; i++) begin
            ack = 1'b1; err = (i != 1);
            @(negedge clk);
            n_checks++;
            if ({busy, rsp_valid, wbm_stb, cmd_ready} !== 4'b0001)
                $display("FAIL spurious_ack: got %b want 0001", {busy, rsp_valid, wbm_stb, cmd_ready});
            else n_pass++;
        end
        ack = 1'b0; err = 1'b0;
    endtask

    task automatic test_reset_mid_bus();
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0020; cmd_dat = 32'h0; cmd_sel = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (wbm_stb !== 1'b1) $display("FAIL rst_mid_stb: got %b want 1", wbm_stb);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({wbm_cyc, wbm_stb, rsp_valid, busy, cmd_ready, wbm_adr} !== {5'b00001, 32'h0})
            $display("FAIL rst_mid_drop: got %b_%h want 00001_00000000",
                     {wbm_cyc, wbm_stb, rsp_valid, busy, cmd_ready}, wbm_adr);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            ack = 1'b1;
            @(negedge clk);
            n_checks++;
            if ({rsp_valid, wbm_stb} !== 2'b00)
                $display("FAIL rst_mid_quiet: got v=%b stb=%b want 0 0", rsp_valid, wbm_stb);
            else n_pass++;
        end
        ack = 1'b0;
        run_txn("after_reset", 1'b0, 32'h3000_0024, 32'h0, 4'hF, 2, 0, 32'hFEED_0042, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            int em;
            em = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            run_txn("random", 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
                    int'($urandom_range(0, 10)), em, $urandom, int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_error();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_spurious_ack();
        test_reset_mid_bus();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
